// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encoding and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_EQ    = 4'h3,
    OP_GT    = 4'h4,
    OP_LT    = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_NOT   = 4'h9,
    OP_SHL   = 4'hA,
    OP_SRA   = 4'hB,
    OP_MIN   = 4'hC,
    OP_MAX   = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } alu_opcode_t;

endpackage : alu_pkg

// File: rtl/alu_compute.sv
// Combinational opcode decode and datapath for the execute-stage ALU.
// All arithmetic wraps modulo 2^WIDTH; compares yield 1/0 in bit 0.
module alu_compute
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  alu_opcode_t      op_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] sra_s;
  logic             eq_s;
  logic             gt_s;
  logic             lt_s;
  logic [WIDTH-1:0] eq_ext_s;
  logic [WIDTH-1:0] gt_ext_s;
  logic [WIDTH-1:0] lt_ext_s;

  // Every 4-bit code has an enum member, so the cast is total.
  assign op_s = alu_opcode_t'(opcode);

  // Wrapping arithmetic: the low WIDTH bits are identical for signed and
  // unsigned interpretation, so plain unsigned operators suffice.
  assign sum_s  = a + b;
  assign diff_s = a - b;
  assign prod_s = a * b;

  // Shift amount uses only the two low bits of B.
  assign shl_s = a << b[1:0];
  assign sra_s = $signed(a) >>> b[1:0];

  // Signed relational flags, shared by compare and min/max.
  assign eq_s = (a == b);
  assign gt_s = ($signed(a) > $signed(b));
  assign lt_s = ($signed(a) < $signed(b));

  assign eq_ext_s = {{(WIDTH-1){1'b0}}, eq_s};
  assign gt_ext_s = {{(WIDTH-1){1'b0}}, gt_s};
  assign lt_ext_s = {{(WIDTH-1){1'b0}}, lt_s};

  // Opcode select; reserved codes produce zero.
  always_comb begin
    result = '0;
    case (op_s)
      OP_ADD:   result = sum_s;
      OP_SUB:   result = diff_s;
      OP_MUL:   result = prod_s;
      OP_EQ:    result = eq_ext_s;
      OP_GT:    result = gt_ext_s;
      OP_LT:    result = lt_ext_s;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL:   result = shl_s;
      OP_SRA:   result = sra_s;
      OP_MIN:   result = lt_s ? a : b;
      OP_MAX:   result = gt_s ? a : b;
      OP_RSV_E: result = '0;
      OP_RSV_F: result = '0;
      default:  result = '0;
    endcase
  end

endmodule : alu_compute

// File: rtl/alu_core.sv
// Execute-stage ALU: combinational datapath followed by a single enabled
// result register. Reset clears the result asynchronously.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic [3:0]       opcode_in,
  input  logic [WIDTH-1:0] alu_input1,
  input  logic [WIDTH-1:0] alu_input2,
  output logic [WIDTH-1:0] alu_output
);

  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] result_r;

  alu_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .opcode (opcode_in),
    .a      (alu_input1),
    .b      (alu_input2),
    .result (result_s)
  );

  // Result register: cleared by reset, loads only on enabled edges.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      result_r <= '0;
    end else if (enable_in) begin
      result_r <= result_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign alu_output = result_r;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (WIDTH = 4).
module tb_alu_core;

  logic       clock_in;
  logic       reset_in;
  logic       enable_in;
  logic [3:0] opcode_in;
  logic [3:0] alu_input1;
  logic [3:0] alu_input2;
  logic [3:0] alu_output;

  int n_checks = 0;
  int n_errors = 0;

  alu_core #(.WIDTH(4)) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .enable_in  (enable_in),
    .opcode_in  (opcode_in),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_output (alu_output)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  function automatic int sval(input logic [3:0] v);
    return v[3] ? (int'(v) - 16) : int'(v);
  endfunction

  // Reference model written with integer arithmetic, truncated at the end.
  function automatic logic [3:0] model(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int sa, sb, r;
    sa = sval(a);
    sb = sval(b);
    case (op)
      4'h0: r = sa + sb;
      4'h1: r = sa - sb;
      4'h2: r = sa * sb;
      4'h3: r = (sa == sb) ? 1 : 0;
      4'h4: r = (sa > sb) ? 1 : 0;
      4'h5: r = (sa < sb) ? 1 : 0;
      4'h6: r = int'(a) & int'(b);
      4'h7: r = int'(a) | int'(b);
      4'h8: r = int'(a) ^ int'(b);
      4'h9: r = 15 - int'(a);
      4'hA: r = int'(a) * (1 << (int'(b) % 4));
      4'hB: r = (sa >= 0) ? (sa / (1 << (int'(b) % 4)))
                          : -(((-sa) + (1 << (int'(b) % 4)) - 1) / (1 << (int'(b) % 4)));
      4'hC: r = (sa < sb) ? sa : sb;
      4'hD: r = (sa > sb) ? sa : sb;
      default: r = 0;
    endcase
    return 4'(r & 15);
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, clock once, sample 1 ns after the rising edge.
  task automatic step(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clock_in);
    opcode_in  = op;
    alu_input1 = a;
    alu_input2 = b;
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    reset_in   = 1'b0;
    enable_in  = 1'b0;
    opcode_in  = 4'h0;
    alu_input1 = 4'h0;
    alu_input2 = 4'h0;

    // Reset state
    #2;
    check("reset_initial", alu_output, 4'h0);
    @(negedge clock_in);
    reset_in = 1'b1;
    enable_in = 1'b1;
    step(4'h0, 4'h3, 4'h4);
    check("add_3_4", alu_output, 4'h7);

    // Mid-cycle async reset, held across an enabled edge
    #2;
    reset_in = 1'b0;
    #1;
    check("async_reset_midcycle", alu_output, 4'h0);
    step(4'h0, 4'h1, 4'h1);
    check("reset_held_enabled", alu_output, 4'h0);

    // Release with enable low, then enable
    @(negedge clock_in);
    reset_in  = 1'b1;
    enable_in = 1'b0;
    step(4'h0, 4'h3, 4'h2);
    check("enable_low_hold", alu_output, 4'h0);
    enable_in = 1'b1;
    step(4'h0, 4'h3, 4'h2);
    check("enable_add_3_2", alu_output, 4'h5);

    // Spot checks with hand-computed values
    step(4'h0, 4'h7, 4'h1); check("add_7_1", alu_output, 4'h8);
    step(4'h1, 4'h0, 4'h1); check("sub_0_1", alu_output, 4'hF);
    step(4'h2, 4'h3, 4'h5); check("mul_3_5", alu_output, 4'hF);
    step(4'h2, 4'h8, 4'h8); check("mul_m8_m8", alu_output, 4'h0);
    step(4'h3, 4'h5, 4'h5); check("eq_5_5", alu_output, 4'h1);
    step(4'h4, 4'hF, 4'h1); check("gt_m1_1", alu_output, 4'h0);
    step(4'h4, 4'h7, 4'h8); check("gt_7_m8", alu_output, 4'h1);
    step(4'h5, 4'h8, 4'h7); check("lt_m8_7", alu_output, 4'h1);
    step(4'h6, 4'hC, 4'hA); check("and_c_a", alu_output, 4'h8);
    step(4'h7, 4'hC, 4'hA); check("or_c_a", alu_output, 4'hE);
    step(4'h8, 4'hC, 4'hA); check("xor_c_a", alu_output, 4'h6);
    step(4'h9, 4'h5, 4'h0); check("not_5", alu_output, 4'hA);
    step(4'hB, 4'h8, 4'h2); check("sra_m8_2", alu_output, 4'hE);
    step(4'hA, 4'h3, 4'h3); check("shl_3_3", alu_output, 4'h8);
    step(4'hC, 4'hD, 4'h2); check("min_m3_2", alu_output, 4'hD);
    step(4'hD, 4'hD, 4'h2); check("max_m3_2", alu_output, 4'h2);
    step(4'hE, 4'h7, 4'h7); check("rsv_e", alu_output, 4'h0);
    step(4'hF, 4'hF, 4'hF); check("rsv_f", alu_output, 4'h0);

    // Exhaustive sweep of every opcode and operand pair against the model
    for (int op = 0; op < 16; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          step(4'(op), 4'(a), 4'(b));
          check($sformatf("sweep_op%0h_a%0h_b%0h", op, a, b), alu_output,
                model(4'(op), 4'(a), 4'(b)));
        end
      end
    end

    // Latency: new operands each cycle show up exactly one edge later
    prev = alu_output;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_in);
      opcode_in  = 4'h0;
      alu_input1 = 4'(i);
      alu_input2 = 4'(i + 3);
      #1;
      check($sformatf("latency_before_%0d", i), alu_output, prev);
      @(posedge clock_in);
      #1;
      check($sformatf("latency_after_%0d", i), alu_output, 4'(2 * i + 3));
      prev = alu_output;
    end

    // Enable dropped for three cycles: output frozen despite changing inputs
    enable_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'h7, 4'(i + 8), 4'h1);
      check($sformatf("freeze_%0d", i), alu_output, 4'hD);
    end

    // Reset asserted inside the disabled window
    #2;
    reset_in = 1'b0;
    #1;
    check("reset_in_freeze", alu_output, 4'h0);
    step(4'h7, 4'hF, 4'hF);
    check("reset_in_freeze_edge", alu_output, 4'h0);
    @(negedge clock_in);
    reset_in = 1'b1;
    step(4'h7, 4'hF, 4'hF);
    check("disabled_after_reset", alu_output, 4'h0);
    enable_in = 1'b1;
    step(4'h7, 4'h9, 4'h2);
    check("reenable_or", alu_output, 4'hB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_core
